csr_reg_bank: RTL and testbench

//  Parametrised CSR register bank behind an APB slave port. Successor to the single 8-bit enable-gated register.

---
 rtl/csr_bank_pkg.sv | 20 ++
 rtl/csr_reg_cell.sv | 40 ++++
 rtl/csr_reg_bank.sv | 118 +++++++++++
 tb/tb_csr_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_bank_pkg.sv
// Shared types and helpers for the CSR register bank: transfer FSM states,
// per-register access modes and the strobe-to-mask expansion.
package csr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;

    // One byte lane of a write mask from its strobe bit.
    function automatic logic [7:0] lane_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/csr_reg_cell.sv
// Single CSR register: RW with byte mask, RO pass-through of hardware data,
// or W1C sticky status bits set by hardware and cleared by software.
module csr_reg_cell
    import csr_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [1:0]            MODE       = MODE_RW,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [DATA_WIDTH-1:0] hw_data,
    input  logic [DATA_WIDTH-1:0] hw_set,
    output logic [DATA_WIDTH-1:0] value
);

    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] nxt;

    // A hardware set in the same cycle as a software clear leaves the bit set.
    always_comb begin
        nxt = stored;
        case (MODE)
            MODE_RW:  if (we) nxt = (stored & ~mask) | (wdata & mask);
            MODE_W1C: nxt = (stored & ~(we ? (wdata & mask) : '0)) | hw_set;
            default:  nxt = stored;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stored <= RST_VAL;
        else        stored <= nxt;
    end

    assign value = (MODE == MODE_RO) ? hw_data : stored;

endmodule

// File: rtl/csr_reg_bank.sv
// APB slave front-end for a bank of CSR cells: setup/access FSM with wait
// states, address decode, error response, read mux and write-commit pulses.
module csr_reg_bank
    import csr_bank_pkg::*;
#(
    parameter int                             DATA_WIDTH  = 8,
    parameter int                             NUM_REGS    = 4,
    parameter int                             ADDR_WIDTH  = 3,
    parameter int                             WAIT_STATES = 0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL     = '0,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pready,
    output logic                           o_pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);

    state_t                state;
    state_t                state_next;
    logic [3:0]            cnt;
    logic                  ready;
    logic                  addr_ok;
    logic                  ro_hit;
    logic                  err;
    logic                  wr_commit;
    logic [NUM_REGS-1:0]   sel;
    logic [NUM_REGS-1:0]   we;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] rd_mux;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (i_psel && !i_penable) state_next = SETUP;
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (ready)        state_next = (i_psel && !i_penable) ? SETUP : IDLE;
                else if (!i_psel) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode by loop so addresses beyond NUM_REGS simply select nothing.
    always_comb begin
        sel    = '0;
        ro_hit = 1'b0;
        rd_mux = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (i_paddr == ADDR_WIDTH'(k)) begin
                sel[k] = 1'b1;
                ro_hit = RO_MASK[k];
                rd_mux = o_regs[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        mask = '0;
        for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
            mask[b*8 +: 8] = lane_mask(i_pstrb[b]);
        end
    end

    always_comb begin
        ready     = (state == ACCESS) && (cnt == 4'(WAIT_STATES));
        addr_ok   = |sel;
        err       = ready && (!addr_ok || (i_pwrite && ro_hit));
        wr_commit = i_psel && i_penable && ready && i_pwrite && !err;
        we        = wr_commit ? sel : '0;
        o_pready  = ready;
        o_pslverr = err;
        o_prdata  = (ready && !i_pwrite && addr_ok) ? rd_mux : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            o_wr_pulse <= '0;
        end else begin
            cnt        <= (state == ACCESS && state_next == ACCESS) ? cnt + 4'd1 : '0;
            o_wr_pulse <= we;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        csr_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (RO_MASK[k] ? MODE_RO : (W1C_MASK[k] ? MODE_W1C : MODE_RW)),
            .RST_VAL    (RST_VAL[k*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .we      (we[k]),
            .wdata   (i_pwdata),
            .mask    (mask),
            .hw_data (i_hw_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .hw_set  (i_hw_set[k*DATA_WIDTH +: DATA_WIDTH]),
            .value   (o_regs[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_csr_reg_bank.sv
// Bench for csr_reg_bank: 16-bit, 4 registers (reg2 W1C, reg3 RO), 2 wait
// states; directed scenarios plus random transfers against an array model.
module tb_csr_reg_bank;

    localparam int          DW  = 16;
    localparam int          NR  = 4;
    localparam int          AW  = 3;
    localparam int          WS  = 2;
    localparam logic [63:0] RST = 64'h5555_00F0_3C11_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [1:0]    pstrb = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [63:0]   hw_data = '0;
    logic [63:0]   hw_set = '0;
    logic [63:0]   regs;
    logic [NR-1:0] wr_pulse;

    int checks = 0;
    int passes = 0;

    logic [15:0] mreg [3];

    csr_reg_bank #(
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS),
        .RST_VAL     (RST),
        .RO_MASK     (4'b1000),
        .W1C_MASK    (4'b0100)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_psel     (psel),
        .i_penable  (penable),
        .i_pwrite   (pwrite),
        .i_paddr    (paddr),
        .i_pwdata   (pwdata),
        .i_pstrb    (pstrb),
        .o_prdata   (prdata),
        .o_pready   (pready),
        .o_pslverr  (pslverr),
        .i_hw_data  (hw_data),
        .i_hw_set   (hw_set),
        .o_regs     (regs),
        .o_wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] mval(input logic [2:0] a);
        case (a)
            3'd0:    return mreg[0];
            3'd1:    return mreg[1];
            3'd2:    return mreg[2];
            3'd3:    return hw_data[63:48];
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [63:0] exp_regs();
        return {hw_data[63:48], mreg[2], mreg[1], mreg[0]};
    endfunction

    task automatic model_reset();
        mreg[0] = RST[15:0];
        mreg[1] = RST[31:16];
        mreg[2] = RST[47:32];
    endtask

    // Complete APB transfer starting now (posedge+#1), ending at posedge+#1 after commit.
    task automatic xfer(input logic wr, input logic [2:0] addr, input logic [15:0] wd,
                        input logic [1:0] st, input logic [63:0] hs);
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [15:0] msk;
        logic [15:0] clr;
        logic [3:0]  exp_pulse;
        logic        got;
        int          cyc;
        exp_err   = (addr > 3'd3) || (wr && addr == 3'd3);
        exp_rd    = (wr || exp_err) ? 16'h0 : mval(addr);
        exp_pulse = (wr && !exp_err) ? 4'(1 << addr) : 4'h0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        checks++;
        if (wr_pulse !== 4'h0) $display("FAIL pulse_width: got %b expected 0000", wr_pulse);
        else passes++;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (pready === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!got) begin
            $display("FAIL pready_timeout: no pready after %0d cycles addr=%0d", cyc, addr);
            psel = 1'b0; penable = 1'b0;
            return;
        end
        if (cyc != WS + 2) $display("FAIL latency: got %0d cycles expected %0d", cyc, WS + 2);
        else passes++;
        checks++;
        if (pslverr !== exp_err) $display("FAIL pslverr addr=%0d wr=%0b: got %b expected %b", addr, wr, pslverr, exp_err);
        else passes++;
        checks++;
        if (prdata !== exp_rd) $display("FAIL prdata addr=%0d: got %h expected %h", addr, prdata, exp_rd);
        else passes++;
        hw_set = hs;
        @(posedge clk); #1;
        hw_set = '0; psel = 1'b0; penable = 1'b0;
        msk = {{8{st[1]}}, {8{st[0]}}};
        if (wr && !exp_err && addr < 3'd2) mreg[addr[1:0]] = (mreg[addr[1:0]] & ~msk) | (wd & msk);
        clr = (wr && !exp_err && addr == 3'd2) ? (wd & msk) : 16'h0;
        mreg[2] = (mreg[2] & ~clr) | hs[47:32];
        checks++;
        if (wr_pulse !== exp_pulse) $display("FAIL wr_pulse addr=%0d: got %b expected %b", addr, wr_pulse, exp_pulse);
        else passes++;
        checks++;
        if (regs !== exp_regs()) $display("FAIL regs: got %h expected %h", regs, exp_regs());
        else passes++;
    endtask

    task automatic test_reset();
        hw_data = 64'hC3C3_1111_2222_3333;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0) $display("FAIL reset_resp: got pready=%b pslverr=%b expected 0 0", pready, pslverr);
        else passes++;
        checks++;
        if (prdata !== 16'h0) $display("FAIL reset_prdata: got %h expected 0000", prdata);
        else passes++;
        checks++;
        if (wr_pulse !== 4'h0) $display("FAIL reset_pulse: got %b expected 0000", wr_pulse);
        else passes++;
        checks++;
        if (regs !== 64'hC3C3_00F0_3C11_0000) $display("FAIL reset_regs: got %h expected %h", regs, 64'hC3C3_00F0_3C11_0000);
        else passes++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 5; a++) xfer(1'b0, 3'(a), 16'h0, 2'b00, 64'h0);
    endtask

    task automatic test_strobe();
        xfer(1'b1, 3'd0, 16'hBEEF, 2'b10, 64'h0);
        checks++;
        if (regs[15:0] !== 16'hBE00) $display("FAIL strobe_hi: got %h expected BE00", regs[15:0]);
        else passes++;
        xfer(1'b1, 3'd1, 16'hFFFF, 2'b00, 64'h0);
        checks++;
        if (regs[31:16] !== 16'h3C11) $display("FAIL strobe_none: got %h expected 3C11", regs[31:16]);
        else passes++;
        xfer(1'b1, 3'd1, 16'h005A, 2'b01, 64'h0);
    endtask

    task automatic test_w1c();
        xfer(1'b1, 3'd2, 16'h0030, 2'b11, 64'hFFFF_0010_FFFF_FFFF);
        checks++;
        if (regs[47:32] !== 16'h00D0) $display("FAIL w1c_set_wins: got %h expected 00D0", regs[47:32]);
        else passes++;
        xfer(1'b0, 3'd2, 16'h0, 2'b00, 64'h0);
    endtask

    task automatic test_errors();
        xfer(1'b1, 3'd5, 16'hAAAA, 2'b11, 64'h0);
        xfer(1'b1, 3'd3, 16'hAAAA, 2'b11, 64'h0);
        xfer(1'b0, 3'd7, 16'h0, 2'b00, 64'h0);
        xfer(1'b0, 3'd3, 16'h0, 2'b00, 64'h0);
    endtask

    task automatic test_idle_penable();
        int seen;
        seen = 0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'd0; pwdata = 16'h1234; pstrb = 2'b11;
        repeat (4) begin
            @(negedge clk);
            if (pready !== 1'b0) seen++;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (seen != 0) $display("FAIL idle_penable: got %0d pready cycles expected 0", seen);
        else passes++;
        checks++;
        if (regs !== exp_regs() || wr_pulse !== 4'h0) $display("FAIL idle_penable_state: got %h/%b expected %h/0000", regs, wr_pulse, exp_regs());
        else passes++;
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 16'h7777; pstrb = 2'b11;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (pready !== 1'b0 || wr_pulse !== 4'h0) seen++;
        end
        @(posedge clk); #1;
        checks++;
        if (seen != 0) $display("FAIL abort_response: got %0d active cycles expected 0", seen);
        else passes++;
        checks++;
        if (regs !== exp_regs()) $display("FAIL abort_regs: got %h expected %h", regs, exp_regs());
        else passes++;
        xfer(1'b0, 3'd1, 16'h0, 2'b00, 64'h0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] hs;
        for (int i = 0; i < 40; i++) begin
            hw_data = {$urandom(), $urandom()};
            hs = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : 64'h0;
            xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 16'($urandom()),
                 2'($urandom_range(0, 3)), hs);
        end
    endtask

    task automatic test_reset_mid();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 16'h1234; pstrb = 2'b11;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 16'h0) $display("FAIL midreset_resp: got %b %b %h expected 0 0 0000", pready, pslverr, prdata);
        else passes++;
        checks++;
        if (regs !== exp_regs() || wr_pulse !== 4'h0) $display("FAIL midreset_regs: got %h/%b expected %h/0000", regs, wr_pulse, exp_regs());
        else passes++;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 3'd1, 16'h0, 2'b00, 64'h0);
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_strobe();
        test_w1c();
        test_errors();
        test_idle_penable();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
